// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (IF) and data (DM) requesters
// DM has priority; a bounded DM streak guarantees IF forward progress.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    state_t            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              dm_win, if_win, fwd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            streak_q   <= streak_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        streak_d    = streak_q;
        dm_win      = 1'b0;
        if_win      = 1'b0;
        fwd         = 1'b0;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_gnt_o    = 1'b0;
        dm_rvalid_o = 1'b0;
        dm_rdata_o  = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        case (state_q)
            S_IDLE: begin
                dm_win = dm_req_i && !((streak_q == STREAK_MAX) && if_req_i);
                if_win = if_req_i && !dm_win;
                if (dm_win) begin
                    dm_gnt_o   = 1'b1;
                    owner_dm_d = 1'b1;
                    we_d       = dm_we_i;
                    addr_d     = dm_addr_i;
                    wdata_d    = dm_wdata_i;
                    // Streak only grows while IF is actually being held off.
                    if (!if_req_i)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + SW'(1);
                    state_d = S_ISSUE;
                end else if (if_win) begin
                    if_gnt_o   = 1'b1;
                    owner_dm_d = 1'b0;
                    we_d       = 1'b0;
                    addr_d     = if_addr_i;
                    wdata_d    = '0;
                    streak_d   = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                if (mem_gnt_i) begin
                    fwd     = mem_rvalid_i;
                    state_d = mem_rvalid_i ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    fwd     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Store acks carry no data back to DM.
        if (fwd) begin
            if (owner_dm_q) begin
                dm_rvalid_o = 1'b1;
                dm_rdata_o  = we_q ? '0 : mem_rdata_i;
            end else begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Two instances (streak limits 4 and 1) share stimulus and are checked against a transaction model.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    logic        if_gnt_w[2], if_rvalid_w[2], dm_gnt_w[2], dm_rvalid_w[2], mem_req_w[2], mem_we_w[2];
    logic [31:0] if_rdata_w[2], dm_rdata_w[2], mem_addr_w[2], mem_wdata_w[2];

    int tot = 0;
    int bad = 0;

    bit          m_busy[2], m_acc[2], m_own_dm[2], m_we[2];
    logic [31:0] m_addr[2], m_wdata[2];
    int          m_streak[2];
    int          gq0[$], gq1[$];
    int          exp4[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int          exp1[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_w[0]),
        .if_rvalid_o(if_rvalid_w[0]), .if_rdata_o(if_rdata_w[0]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt_w[0]), .dm_rvalid_o(dm_rvalid_w[0]), .dm_rdata_o(dm_rdata_w[0]),
        .mem_req_o(mem_req_w[0]), .mem_we_o(mem_we_w[0]), .mem_addr_o(mem_addr_w[0]),
        .mem_wdata_o(mem_wdata_w[0]), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_w[1]),
        .if_rvalid_o(if_rvalid_w[1]), .if_rdata_o(if_rdata_w[1]),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt_w[1]), .dm_rvalid_o(dm_rvalid_w[1]), .dm_rdata_o(dm_rdata_w[1]),
        .mem_req_o(mem_req_w[1]), .mem_we_o(mem_we_w[1]), .mem_addr_o(mem_addr_w[1]),
        .mem_wdata_o(mem_wdata_w[1]), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: one pending request per instance, outputs derived at mid-cycle.
    always @(negedge clk) begin : model
        logic        e_ig, e_iv, e_dg, e_dv, e_mr, e_mw;
        logic [31:0] e_ir, e_dr, e_ma, e_mwd;
        logic [133:0] ev, av;
        int          mx;
        bit          dwin, iwin, resp;
        for (int d = 0; d < 2; d++) begin
            mx = (d == 0) ? 4 : 1;
            {e_ig, e_iv, e_dg, e_dv, e_mr, e_mw} = '0;
            {e_ir, e_dr, e_ma, e_mwd} = '0;
            resp = 0;
            if (rst) begin
                m_busy[d]   = 0;
                m_streak[d] = 0;
            end else if (!m_busy[d]) begin
                dwin = dm_req && !(m_streak[d] == mx && if_req);
                iwin = if_req && !dwin;
                if (dwin) begin
                    e_dg = 1;
                    m_streak[d] = if_req ? ((m_streak[d] + 1 > mx) ? mx : m_streak[d] + 1) : 0;
                    m_busy[d] = 1; m_acc[d] = 0; m_own_dm[d] = 1;
                    m_we[d] = dm_we; m_addr[d] = dm_addr; m_wdata[d] = dm_wdata;
                end else if (iwin) begin
                    e_ig = 1;
                    m_streak[d] = 0;
                    m_busy[d] = 1; m_acc[d] = 0; m_own_dm[d] = 0;
                    m_we[d] = 0; m_addr[d] = if_addr; m_wdata[d] = 0;
                end
            end else if (!m_acc[d]) begin
                e_mr = 1; e_mw = m_we[d]; e_ma = m_addr[d]; e_mwd = m_wdata[d];
                if (mem_gnt) begin
                    if (mem_rvalid) resp = 1;
                    else m_acc[d] = 1;
                end
            end else if (mem_rvalid) begin
                resp = 1;
            end
            if (resp) begin
                m_busy[d] = 0;
                if (m_own_dm[d]) begin
                    e_dv = 1; e_dr = m_we[d] ? 32'h0 : mem_rdata;
                end else begin
                    e_iv = 1; e_ir = mem_rdata;
                end
            end
            ev = {e_ig, e_iv, e_ir, e_dg, e_dv, e_dr, e_mr, e_mw, e_ma, e_mwd};
            av = {if_gnt_w[d], if_rvalid_w[d], if_rdata_w[d], dm_gnt_w[d], dm_rvalid_w[d],
                  dm_rdata_w[d], mem_req_w[d], mem_we_w[d], mem_addr_w[d], mem_wdata_w[d]};
            tot++;
            if (ev !== av) begin
                bad++;
                $display("FAIL model dut%0d t=%0t act=%h exp=%h", d, $time, av, ev);
            end
            if (if_gnt_w[d]) begin
                if (d == 0) gq0.push_back(0); else gq1.push_back(0);
            end
            if (dm_gnt_w[d]) begin
                if (d == 0) gq0.push_back(1); else gq1.push_back(1);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; if_req = 0; dm_req = 0; dm_we = 0; mem_gnt = 0; mem_rvalid = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        step();
        #1;
        chk("rst_mem_req", mem_req_w[0], 0);
        chk("rst_gnt", {if_gnt_w[0], dm_gnt_w[0]}, 0);
        step();
        rst = 0;

        // Single DM load with a wait cycle; then IF proves the arbiter is idle.
        dm_req = 1; dm_we = 0; dm_addr = 32'h100;
        #1; chk("t1_dm_gnt", dm_gnt_w[0], 1);
        step(); dm_req = 0; mem_gnt = 1;
        #1; chk("t1_mem_req", mem_req_w[0], 1); chk("t1_mem_addr", mem_addr_w[0], 32'h100);
        step(); mem_gnt = 0;
        #1; chk("t1_wait_req", mem_req_w[0], 0); chk("t1_wait_rv", dm_rvalid_w[0], 0);
        step(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #1; chk("t1_dm_rvalid", dm_rvalid_w[0], 1); chk("t1_dm_rdata", dm_rdata_w[0], 32'hDEADBEEF);
        step(); mem_rvalid = 0; if_req = 1; if_addr = 32'h40;
        #1; chk("t1_idle_if_gnt", if_gnt_w[0], 1);
        step(); if_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h11;
        #1; chk("t1_if_rdata", if_rdata_w[0], 32'h11); chk("t1_if_mem_we", mem_we_w[0], 0);
        step(); mem_gnt = 0; mem_rvalid = 0;

        // Both requesters always asking: streak limit decides grant order.
        gq0.delete(); gq1.delete();
        if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h80; if_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            mem_gnt = 0; mem_rvalid = 0;
            step(); mem_gnt = 1;
            step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1000 + i;
            step();
        end
        if_req = 0; dm_req = 0; mem_rvalid = 0;
        step();
        chk("t3_cnt4", gq0.size(), 10);
        chk("t3_cnt1", gq1.size(), 10);
        if (gq0.size() == 10 && gq1.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("t3_order4_%0d", i), gq0[i], exp4[i]);
                chk($sformatf("t2_order1_%0d", i), gq1[i], exp1[i]);
            end
        end

        // Store with zero-latency memory: ack carries no data.
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h55AA;
        #1; chk("t4_dm_gnt", dm_gnt_w[0], 1);
        step(); dm_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1234;
        #1; chk("t4_mem_we", mem_we_w[0], 1); chk("t4_mem_wdata", mem_wdata_w[0], 32'h55AA);
        chk("t4_dm_rvalid", dm_rvalid_w[0], 1); chk("t4_dm_rdata", dm_rdata_w[0], 0);
        step(); mem_gnt = 0; mem_rvalid = 0; dm_we = 0; dm_wdata = 0;
        #1; chk("t4_idle_req", mem_req_w[0], 0);

        // Memory stalls in ISSUE while spurious rvalids appear.
        if_req = 1; if_addr = 32'h300;
        step(); if_req = 0;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = i[0]; mem_rdata = 32'hBAD0 + i;
            #1; chk("t5_req", mem_req_w[0], 1); chk("t5_addr", mem_addr_w[0], 32'h300);
            chk("t5_no_rv", {if_rvalid_w[0], dm_rvalid_w[0]}, 0);
            step();
        end
        mem_rvalid = 0; mem_gnt = 1;
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE;
        #1; chk("t5_if_rv", if_rvalid_w[0], 1); chk("t5_if_rdata", if_rdata_w[0], 32'hCAFE);
        step(); mem_rvalid = 0;

        // Reset in ISSUE drops mem_req immediately.
        dm_req = 1; dm_addr = 32'h600;
        step(); dm_req = 0;
        #1; chk("t6_issue_req", mem_req_w[0], 1);
        rst = 1;
        #1; chk("t6_issue_rst_req", mem_req_w[0], 0);
        step(); rst = 0;

        // Reset in WAIT, then late rvalid ignored and IF served normally.
        dm_req = 1; dm_addr = 32'h400;
        step(); dm_req = 0; mem_gnt = 1;
        step(); mem_gnt = 0;
        rst = 1; mem_rvalid = 1; mem_rdata = 32'hBADD;
        #1; chk("t6_rst_req", mem_req_w[0], 0); chk("t6_rst_rv", dm_rvalid_w[0], 0);
        step(); rst = 0; if_req = 1; if_addr = 32'h500;
        #1; chk("t6_late_rv", {if_rvalid_w[0], dm_rvalid_w[0]}, 0);
        chk("t6_if_gnt", if_gnt_w[0], 1);
        step(); if_req = 0; mem_rvalid = 0; mem_gnt = 1;
        step(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        #1; chk("t6_if_rdata", if_rdata_w[0], 32'h77);
        step(); mem_rvalid = 0;
        step();

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
